// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
// State encoding, algorithm selectors, counter-width helper.
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int ALGO_SUB = 0;
  localparam int ALGO_BIN = 1;

  function automatic int kw(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/gcd_if.sv
// Operand/result handshake bundle for gcd_engine.
// master = producer/consumer side, slave = engine side.
interface gcd_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic [WIDTH-1:0] iter_cnt;
  logic             err_zero;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out,
    input  iter_cnt, err_zero
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out,
    output iter_cnt, err_zero
  );

endinterface

// File: rtl/gcd_step.sv
// One CALC decision: next A/B/k, terminate, result, zero and modify flags.
// In: a, b, k. Out: a_nxt, b_nxt, k_nxt, term, res, zero, modf.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = ALGO_SUB,
  parameter int KW    = kw(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             term,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             modf
);

  localparam bit BIN = (ALGO == ALGO_BIN);

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_nxt = k;
    term  = 1'b0;
    res   = '0;
    zero  = 1'b0;
    modf  = 1'b0;
    if (a == '0 && b == '0) begin
      term = 1'b1;
      zero = 1'b1;
    end else if (a == '0) begin
      term = 1'b1;
      res  = b << k;
    end else if (b == '0 || a == b) begin
      term = 1'b1;
      res  = a << k;
    end else begin
      modf = 1'b1;
      if (BIN && !a[0] && !b[0]) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_nxt = k + KW'(1);
      end else if (BIN && !a[0]) begin
        a_nxt = a >> 1;
      end else if (BIN && !b[0]) begin
        b_nxt = b >> 1;
      end else if (a > b) begin
        a_nxt = a - b;
      end else begin
        b_nxt = b - a;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine: IDLE/CALC/DONE FSM, operand and result registers.
// Ports: clk, resetn, bus (gcd_if.slave: operand in, result out).
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = ALGO_SUB
) (
  input logic  clk,
  input logic  resetn,
  gcd_if.slave bus
);

  localparam int KW = kw(WIDTH);

  state_e           st_q, st_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] iter_q;
  logic [WIDTH-1:0] gcd_q;
  logic             err_q;

  logic [WIDTH-1:0] a_nxt, b_nxt, res;
  logic [KW-1:0]    k_nxt;
  logic             term, zero, modf;

  gcd_step #(
    .WIDTH(WIDTH),
    .ALGO (ALGO),
    .KW   (KW)
  ) u_step (
    .a    (a_q),
    .b    (b_q),
    .k    (k_q),
    .a_nxt(a_nxt),
    .b_nxt(b_nxt),
    .k_nxt(k_nxt),
    .term (term),
    .res  (res),
    .zero (zero),
    .modf (modf)
  );

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: if (bus.in_valid) st_d = S_CALC;
      S_CALC: if (term) st_d = S_DONE;
      S_DONE: if (bus.out_ready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) st_q <= S_IDLE;
    else         st_q <= st_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      iter_q <= '0;
      gcd_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a_in;
            b_q    <= bus.b_in;
            k_q    <= '0;
            iter_q <= '0;
          end
        end
        S_CALC: begin
          if (term) begin
            gcd_q <= res;
            err_q <= zero;
          end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
            k_q <= k_nxt;
            // saturate so a long run never wraps to a small count
            if (modf && iter_q != '1)
              iter_q <= iter_q + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (st_q == S_IDLE);
  assign bus.out_valid = (st_q == S_DONE);
  assign bus.gcd_out   = gcd_q;
  assign bus.iter_cnt  = iter_q;
  assign bus.err_zero  = err_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine, both algorithms side by side.
// Table vectors, random vectors against a model, hold and reset sequences.
module tb_gcd_engine;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  gcd_if #(.WIDTH(8)) ifc0 ();
  gcd_if #(.WIDTH(8)) ifc1 ();

  gcd_engine #(.WIDTH(8), .ALGO(0)) dut0 (
    .clk   (clk),
    .resetn(resetn),
    .bus   (ifc0.slave)
  );

  gcd_engine #(.WIDTH(8), .ALGO(1)) dut1 (
    .clk   (clk),
    .resetn(resetn),
    .bus   (ifc1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] i0;
    logic [7:0] i1;
    logic       z;
    int         lat0;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // subtraction count = sum of Euclid quotients minus the last one's extra
  function automatic int ref_sub(input int a, input int b);
    int s, t;
    if (a == 0 || b == 0) return 0;
    s = 0;
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    s = s - 1;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int ref_bin(input int a, input int b);
    int n;
    if (a == 0 || b == 0) return 0;
    n = 0;
    while (a != b) begin
      if (a % 2 == 0 && b % 2 == 0) begin
        a /= 2;
        b /= 2;
      end else if (a % 2 == 0) a /= 2;
      else if (b % 2 == 0) b /= 2;
      else if (a > b) a -= b;
      else b -= a;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  task automatic run(input logic [7:0] a,
                     input logic [7:0] b,
                     output logic [7:0] g0, output logic [7:0] i0,
                     output logic z0, output int l0,
                     output logic [7:0] g1, output logic [7:0] i1,
                     output logic z1, output int l1);
    bit d0, d1;
    int cyc;
    g0 = 'x; i0 = 'x; z0 = 1'bx; l0 = -1;
    g1 = 'x; i1 = 'x; z1 = 1'bx; l1 = -1;
    @(negedge clk);
    chk("in_ready0", 32'(ifc0.in_ready), 1);
    chk("in_ready1", 32'(ifc1.in_ready), 1);
    ifc0.a_in = a; ifc0.b_in = b; ifc0.in_valid = 1'b1;
    ifc1.a_in = a; ifc1.b_in = b; ifc1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc0.in_valid = 1'b0;
    ifc1.in_valid = 1'b0;
    d0 = 0; d1 = 0; cyc = 0;
    while (!(d0 && d1) && cyc < 600) begin
      @(posedge clk);
      cyc++;
      #1;
      if (!d0 && ifc0.out_valid) begin
        d0 = 1; l0 = cyc;
        g0 = ifc0.gcd_out; i0 = ifc0.iter_cnt;
        z0 = ifc0.err_zero;
      end
      if (!d1 && ifc1.out_valid) begin
        d1 = 1; l1 = cyc;
        g1 = ifc1.gcd_out; i1 = ifc1.iter_cnt;
        z1 = ifc1.err_zero;
      end
    end
    if (!(d0 && d1)) chk("done_timeout", 32'({d0, d1}), 3);
    cyc = 0;
    while (!(ifc0.in_ready && ifc1.in_ready) && cyc < 4) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  vec_t       tbl[7];
  logic [7:0] g0, i0, g1, i1;
  logic       z0, z1;
  int         l0, l1;
  int         ra, rb, cyc;

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    ifc0.in_valid = 0; ifc0.a_in = 0; ifc0.b_in = 0; ifc0.out_ready = 1;
    ifc1.in_valid = 0; ifc1.a_in = 0; ifc1.b_in = 0; ifc1.out_ready = 1;

    tbl[0] = '{8'd12,  8'd8,  8'd4,   8'd2,   8'd5,  1'b0, 3};
    tbl[1] = '{8'd0,   8'd0,  8'd0,   8'd0,   8'd0,  1'b1, 1};
    tbl[2] = '{8'd0,   8'd5,  8'd5,   8'd0,   8'd0,  1'b0, 1};
    tbl[3] = '{8'd5,   8'd0,  8'd5,   8'd0,   8'd0,  1'b0, 1};
    tbl[4] = '{8'd7,   8'd7,  8'd7,   8'd0,   8'd0,  1'b0, 1};
    tbl[5] = '{8'd16,  8'd24, 8'd8,   8'd2,   8'd6,  1'b0, 3};
    tbl[6] = '{8'd255, 8'd1,  8'd1,   8'd254, 8'd14, 1'b0, 255};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(ifc0.in_ready), 1);
    chk("rst_out_valid", 32'(ifc0.out_valid), 0);
    chk("rst_gcd",       32'(ifc0.gcd_out), 0);
    chk("rst_err",       32'(ifc0.err_zero), 0);
    chk("rst_iter",      32'(ifc0.iter_cnt), 0);
    chk("rst_out_valid1", 32'(ifc1.out_valid), 0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[n]) begin
      run(tbl[n].a, tbl[n].b, g0, i0, z0, l0, g1, i1, z1, l1);
      chk($sformatf("t%0d_gcd0", n), 32'(g0), 32'(tbl[n].g));
      chk($sformatf("t%0d_gcd1", n), 32'(g1), 32'(tbl[n].g));
      chk($sformatf("t%0d_iter0", n), 32'(i0), 32'(tbl[n].i0));
      chk($sformatf("t%0d_iter1", n), 32'(i1), 32'(tbl[n].i1));
      chk($sformatf("t%0d_err0", n), 32'(z0), 32'(tbl[n].z));
      chk($sformatf("t%0d_err1", n), 32'(z1), 32'(tbl[n].z));
      chk($sformatf("t%0d_lat0", n), 32'(l0), 32'(tbl[n].lat0));
      chk($sformatf("t%0d_lat1", n), 32'(l1), 32'(tbl[n].i1) + 1);
    end

    for (int n = 0; n < 40; n++) begin
      if (n % 4 == 0) begin
        ra = $urandom_range(0, 15);
        rb = $urandom_range(0, 15);
      end else begin
        ra = $urandom_range(0, 255);
        rb = $urandom_range(0, 255);
      end
      run(8'(ra), 8'(rb), g0, i0, z0, l0, g1, i1, z1, l1);
      chk($sformatf("r%0d_gcd0", n), 32'(g0), ref_gcd(ra, rb));
      chk($sformatf("r%0d_gcd1", n), 32'(g1), ref_gcd(ra, rb));
      chk($sformatf("r%0d_iter0", n), 32'(i0), ref_sub(ra, rb));
      chk($sformatf("r%0d_iter1", n), 32'(i1), ref_bin(ra, rb));
      chk($sformatf("r%0d_err0", n), 32'(z0), 32'(ra == 0 && rb == 0));
      chk($sformatf("r%0d_err1", n), 32'(z1), 32'(ra == 0 && rb == 0));
      chk($sformatf("r%0d_lat1", n), 32'(l1), ref_bin(ra, rb) + 1);
    end

    // result held while the consumer stalls
    @(negedge clk);
    ifc0.out_ready = 1'b0;
    ifc0.a_in = 8'd255; ifc0.b_in = 8'd1; ifc0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc0.in_valid = 1'b0;
    cyc = 0;
    while (!ifc0.out_valid && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("hold_seen", 32'(ifc0.out_valid), 1);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(ifc0.out_valid), 1);
      chk("hold_gcd",   32'(ifc0.gcd_out), 1);
      chk("hold_iter",  32'(ifc0.iter_cnt), 254);
      chk("hold_ready", 32'(ifc0.in_ready), 0);
    end
    @(negedge clk);
    ifc0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_valid", 32'(ifc0.out_valid), 0);
    chk("rel_ready", 32'(ifc0.in_ready), 1);

    // reset in the middle of a long calculation
    @(negedge clk);
    ifc0.a_in = 8'd255; ifc0.b_in = 8'd1; ifc0.in_valid = 1'b1;
    ifc1.a_in = 8'd255; ifc1.b_in = 8'd1; ifc1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc0.in_valid = 1'b0;
    ifc1.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy0", 32'(ifc0.in_ready), 0);
    chk("mid_busy1", 32'(ifc1.in_ready), 0);
    resetn = 1'b0;
    #1;
    chk("mr_valid0", 32'(ifc0.out_valid), 0);
    chk("mr_ready0", 32'(ifc0.in_ready), 1);
    chk("mr_iter0",  32'(ifc0.iter_cnt), 0);
    chk("mr_gcd0",   32'(ifc0.gcd_out), 0);
    chk("mr_ready1", 32'(ifc1.in_ready), 1);
    chk("mr_valid1", 32'(ifc1.out_valid), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run(8'd9, 8'd6, g0, i0, z0, l0, g1, i1, z1, l1);
    chk("post_gcd0",  32'(g0), 3);
    chk("post_gcd1",  32'(g1), 3);
    chk("post_iter0", 32'(i0), 2);
    chk("post_iter1", 32'(i1), 3);
    chk("post_lat0",  32'(l0), 3);
    chk("post_err0",  32'(z0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
